// File: rtl/neuron_pkg.sv
// Shared types and constants for the neuron core and its consumers.
// Q16.16 word type, spike-monitor defaults and the event record.
package neuron_pkg;

  typedef logic signed [31:0] q16_16_t;

  localparam q16_16_t VTH = 32'sh001E_0000;
  localparam q16_16_t C0 = 32'sh0001_0000;
  localparam logic [31:0] DROP_TH_D = 32'h0014_0000;
  localparam int PERIOD = 13;

  typedef struct packed {
    logic [15:0] isi;
    logic [31:0] gm;
  } ev_t;

  function automatic logic [15:0] sat_inc16(
    input logic [15:0] x
  );
    return (x == 16'hFFFF) ? x : x + 16'd1;
  endfunction

endpackage

// File: rtl/spike_monitor_ev_hold.sv
// ev_hold_reg: single-entry valid/ready holding register.
// Ports: push/din in, ready in, clr_ovf in; valid/dout/ovf out.
import neuron_pkg::*;

module ev_hold_reg (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  ev_t  din,
  input  logic ready,
  input  logic clr_ovf,
  output logic valid,
  output ev_t  dout,
  output logic ovf
);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      dout <= '0;
      ovf <= 1'b0;
    end else begin
      // A pop in the same cycle frees the slot for the new record.
      if (push && (!valid || ready)) begin
        valid <= 1'b1;
        dout <= din;
      end else if (ready) begin
        valid <= 1'b0;
      end
      if (clr_ovf)
        ovf <= 1'b0;
      else if (push && valid && !ready)
        ovf <= 1'b1;
    end
  end

endmodule

// File: rtl/spike_monitor.sv
// Samples the Q16.16 neuron state once per step, detects spikes from
// the reset drop, counts spikes, tracks ISI and a windowed rate.
// Ports: clk, rst, iv1i/iv1d, iGmi/iGmd, clr_cnt, ev_ready in;
// sample_stb, spike, spike_cnt, rate, rate_stb, ev_* out.
import neuron_pkg::*;

module spike_monitor #(
  parameter int          PERIOD  = 13,
  parameter logic [31:0] DROP_TH = DROP_TH_D,
  parameter int          REFRAC  = 2,
  parameter int          WINDOW  = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] iv1i,
  input  logic [15:0] iv1d,
  input  logic [15:0] iGmi,
  input  logic [15:0] iGmd,
  input  logic        clr_cnt,
  input  logic        ev_ready,
  output logic        sample_stb,
  output logic        spike,
  output logic [15:0] spike_cnt,
  output logic [15:0] rate,
  output logic        rate_stb,
  output logic        ev_valid,
  output logic [15:0] ev_isi,
  output logic [31:0] ev_gm,
  output logic        ev_ovf
);

  localparam int PW = $clog2(PERIOD);
  localparam int WW = $clog2(WINDOW);
  localparam int RW = $clog2(REFRAC + 1);

  logic [PW-1:0] phase;
  logic [WW-1:0] wcnt;
  logic [RW-1:0] refr;
  logic [15:0]   since;
  logic [15:0]   wspk;
  logic          primed;
  logic          has_prev;
  q16_16_t       prev_v;
  q16_16_t       cur_v;
  q16_16_t       cur_gm;

  logic               smp;
  logic               wrap;
  logic               hit;
  logic               drop_ok;
  logic signed [32:0] diff;
  ev_t                ev_in;
  ev_t                ev_q;

  assign cur_v  = {iv1i, iv1d};
  assign cur_gm = {iGmi, iGmd};
  assign smp    = (phase == '0);

  // Sign-extend to 33 bits so the fall never wraps.
  assign diff = $signed({prev_v[31], prev_v})
              - $signed({cur_v[31], cur_v});
  assign drop_ok = (diff >= $signed({1'b0, DROP_TH}));

  assign hit  = smp && primed && (refr == '0) && drop_ok;
  assign wrap = smp && (wcnt == WW'(WINDOW - 1));

  assign ev_in.isi = since;
  assign ev_in.gm  = cur_gm;

  always_ff @(posedge clk) begin
    if (rst) begin
      phase <= '0;
      wcnt <= '0;
      refr <= '0;
      since <= '0;
      wspk <= '0;
      primed <= 1'b0;
      has_prev <= 1'b0;
      prev_v <= '0;
      sample_stb <= 1'b0;
      spike <= 1'b0;
      spike_cnt <= '0;
      rate <= '0;
      rate_stb <= 1'b0;
    end else begin
      sample_stb <= smp;
      spike <= hit;
      rate_stb <= wrap;

      if (phase == PW'(PERIOD - 1))
        phase <= '0;
      else
        phase <= phase + PW'(1);

      if (clr_cnt)
        spike_cnt <= '0;
      else if (hit)
        spike_cnt <= sat_inc16(spike_cnt);

      if (smp) begin
        prev_v <= cur_v;
        primed <= 1'b1;

        if (hit)
          refr <= RW'(REFRAC);
        else if (refr != '0)
          refr <= refr - RW'(1);

        // since = samples elapsed since the last spike.
        since <= hit ? 16'd1 : sat_inc16(since);
        if (hit)
          has_prev <= 1'b1;

        if (wrap) begin
          wcnt <= '0;
          rate <= wspk + {15'd0, hit};
          wspk <= '0;
        end else begin
          wcnt <= wcnt + WW'(1);
          wspk <= wspk + {15'd0, hit};
        end
      end
    end
  end

  ev_hold_reg u_ev (
    .clk     (clk),
    .rst     (rst),
    .push    (hit && has_prev),
    .din     (ev_in),
    .ready   (ev_ready),
    .clr_ovf (clr_cnt),
    .valid   (ev_valid),
    .dout    (ev_q),
    .ovf     (ev_ovf)
  );

  assign ev_isi = ev_q.isi;
  assign ev_gm  = ev_q.gm;

endmodule

// File: doc/spike_monitor.md
Name: spike_monitor

Overview:
- Downstream consumer of the Q16.16 neuron core, which exports membrane potential and synaptic conductance as split 16-bit integer/fraction halves and updates them once every 13 clocks.
- Reassembles both words, samples them once per neuron step and detects spikes from the post-spike reset drop.
- Produces a spike pulse, a saturating spike count, inter-spike intervals (ISI) and a windowed firing rate.
- ISI and Gm snapshot records leave through a valid/ready event port for the host/readout logic.

Parameters:
PERIOD, 13, clocks per neuron update; sample taken when phase counter = 0
DROP_TH, 32'h00140000, Q16.16 minimum step-to-step fall of v that counts as a spike (20.0)
REFRAC, 2, samples after a spike during which detection is inhibited
WINDOW, 1000, samples per firing-rate window

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
iv1i  in  16  signed integer half of v (bits 31:16)
iv1d  in  16  fractional half of v (bits 15:0)
iGmi  in  16  signed integer half of Gm
iGmd  in  16  fractional half of Gm
clr_cnt  in  1  clears spike_cnt and ev_ovf
ev_ready  in  1  consumer accepts event
sample_stb  out  1  one-clock pulse, cycle after each sample
spike  out  1  one-clock pulse per detected spike
spike_cnt  out  16  saturating spike count
rate  out  16  spikes in last completed window
rate_stb  out  1  one-clock pulse when rate updates
ev_valid  out  1  event record pending
ev_isi  out  16  ISI in neuron steps, saturating at 16'hFFFF
ev_gm  out  32  Q16.16 Gm at the spiking sample
ev_ovf  out  1  sticky: an event was dropped

Behaviour:
- Reset:
  - Clock is clk; reset is rst, synchronous and active-high.
  - Every output and internal register clears to 0 on rst. This includes phase counter, primed flag, refractory counter, steps-since-spike, window counter and window spike count.
  - rst mid-operation abandons any pending event without setting ev_ovf.
  - Release of rst is aligned so phase 0 coincides with neuron state s0, when the core's outputs are stable.
- Phase counter: counts 0..PERIOD-1 and wraps. A sample occurs on the clock edge with phase = 0.
- At each sample:
  - cur_v = {iv1i, iv1d} and cur_gm = {iGmi, iGmd}.
  - prev_v <= cur_v and primed <= 1.
  - sample_stb pulses on the following cycle.
- Spike condition:
  - primed = 1, refr = 0, and (prev_v - cur_v) >= DROP_TH.
  - The subtraction is 33-bit signed, so there is no wrap on extreme values.
  - The first sample after reset never spikes.
- On spike:
  - spike pulses exactly 1 clock after the sample edge.
  - spike_cnt increments and saturates at 16'hFFFF.
  - refr <= REFRAC. Otherwise refr decrements by 1 per sample while nonzero.
- ISI tracking:
  - since counts samples and saturates at 16'hFFFF; it resets to 1 on the sample after a spike.
  - The first spike after reset sets has_prev and emits no event.
  - Each later spike emits event {ev_isi = since, ev_gm = cur_gm}.
- Event port:
  - ev_valid holds, with ev_isi and ev_gm stable, until a cycle with ev_ready = 1.
  - New event while ev_valid = 1 and ev_ready = 0: the new event is dropped, the old one is kept, and ev_ovf <= 1.
  - New event in the same cycle as ev_ready = 1 with ev_valid = 1: the new event replaces the old one and ev_valid stays 1.
- Rate window:
  - wcnt counts samples 0..WINDOW-1 and wspk counts spikes in the window.
  - At the sample where wcnt wraps, rate <= wspk plus any spike at that sample, rate_stb pulses, and wspk restarts at 0.
- clr_cnt:
  - Zeroes spike_cnt and ev_ovf.
  - Beats a same-cycle increment: the counter ends at 0.
  - Does not affect rate, ISI state or a pending event.
- Latency: sample edge to spike, event and rate outputs is 1 clock.

Decomposition:
- Shared package `neuron_pkg` holds:
  - Q16.16 typedef `q16_16_t` (signed 32-bit).
  - Constants for VTH, C0, DROP_TH default and PERIOD = 13.
  - Event record struct {isi[15:0], gm[31:0]}.
- One natural sub-module: `ev_hold_reg`, a single-entry valid/ready holding register with an overflow flag.

Test Plan:
- rst held 3 clocks, then v ramps -60.0 → 25.0 in steps of +5.0 per sample, then drops to -50.0 → spike asserts exactly once, 1 clock after that sample edge; spike_cnt = 1; ev_valid stays 0 (first spike).
- Spikes forced every 40 samples with ev_ready = 1 → ev_isi = 40 on every event after the first; ev_gm equals {iGmi, iGmd} at each spiking sample.
- Second spike forced 1 sample after the first with REFRAC = 2 → ignored, spike_cnt unchanged; spike at 3 samples → counted with ev_isi = 3.
- ev_ready = 0 while two spikes occur → first record held unchanged, ev_ovf = 1; clr_cnt then → ev_ovf = 0 and spike_cnt = 0, ev_valid still 1.
- v falls by 19.99 (0x0013FD71) → no spike; falls by exactly 20.0 → spike.
- WINDOW = 100 with 7 spikes, the last on the wrapping sample → rate = 7 with a single rate_stb pulse; v at 0x7FFF0000 then 0x80000000 → spike, with no false negative from wrap.
